// File: rtl/bfsk_modem_top.sv
// bfsk_modem_top: square-wave BFSK loopback modem, modulator plus half-period-length demodulator
module bfsk_modem_top #(
  parameter int HALF0  = 10,
  parameter int HALF1  = 5,
  parameter int THRESH = 7,
  parameter int AMP    = 100,
  parameter int SW     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  input  logic start,
  output logic data_out
);
  localparam int HW = $clog2(HALF0 + 1);
  localparam logic signed [SW-1:0] AMP_S = SW'(AMP);
  if (!(HALF1 <= THRESH && THRESH < HALF0)) begin : g_bad_thresh
    $error("bfsk_modem_top: requires HALF1 <= THRESH < HALF0");
  end
  logic run, din_q, sign, neg, neg_q;
  logic [HW-1:0] hc, reload;
  logic [SW-1:0] lc;
  logic [SW:0] cnt;
  logic signed [SW-1:0] sample;
  assign reload = din_q ? HW'(HALF1 - 1) : HW'(HALF0 - 1);
  assign sample = !run ? '0 : sign ? AMP_S : -AMP_S;
  assign neg    = sample < 0;
  assign cnt    = (SW+1)'(lc) + (SW+1)'(1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      run      <= 1'b0;
      din_q    <= 1'b0;
      sign     <= 1'b1;
      neg_q    <= 1'b0;
      hc       <= '0;
      lc       <= '0;
      data_out <= 1'b0;
    end else begin
      din_q <= data_in === 1'b1;
      run   <= run | start;
      neg_q <= neg;
      // idle preload lets the first half start with the right length right after run rises
      if (!run) hc <= reload;
      else if (hc == '0) begin
        sign <= ~sign;
        hc   <= reload;
      end else hc <= hc - 1'b1;
      if (run && neg != neg_q) begin
        lc       <= '0;
        data_out <= cnt <= (SW+1)'(THRESH);
      end else if (run) lc <= (&lc) ? lc : lc + 1'b1;
    end
endmodule

// File: tb/tb_bfsk_modem_top.sv
// tb_bfsk_modem_top: directed + random BFSK loopback checks against bit-window expectations
module tb_bfsk_modem_top;
  logic clk = 0, reset = 0, data_in = 0, start = 0;
  logic data_out;
  int errors = 0, checks = 0, n = 0, last_t = 0, interval = 0, nt = 0, stable = 0, lat = 0;
  bit prev_pos = 0, b;
  bfsk_modem_top dut (.clk(clk), .reset(reset), .data_in(data_in), .start(start), .data_out(data_out));
  always #5 clk = ~clk;
  task automatic cyc();
    bit cur;
    @(posedge clk);
    #1;
    n++;
    stable++;
    cur = $signed(dut.sample) > 0;
    if (cur != prev_pos) begin
      interval = n - last_t;
      last_t = n;
      nt++;
      prev_pos = cur;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic setd(input bit v);
    if (data_in !== v) stable = 0;
    data_in = v;
  endtask
  task automatic wait_rise();
    lat = 0;
    while (lat < 40 && data_out !== 1'b1) begin
      cyc();
      lat++;
    end
  endtask
  initial begin
    repeat (20) cyc();
    chk("reset_dout", data_out, 0);
    chk("reset_sample", 32'(dut.sample), 0);
    reset = 1;
    for (int i = 0; i < 500; i++) begin
      cyc();
      if (i % 50 == 0) begin
        chk("idle_dout", data_out, 0);
        chk("idle_sample", 32'(dut.sample), 0);
      end
    end
    start = 1;
    cyc();
    cyc();
    start = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      chk("steady0_dout", data_out, 0);
    end
    chk("steady0_half", interval, 10);
    chk("steady0_toggles", 32'(nt >= 8), 1);
    setd(1);
    wait_rise();
    chk("rise_latency", 32'(lat <= 23), 1);
    for (int i = 0; i < 70; i++) begin
      cyc();
      chk("steady1_dout", data_out, 1);
    end
    chk("steady1_half", interval, 5);
    for (int w = 0; w < 100; w++) begin
      setd(w % 2 == 1);
      repeat (100) cyc();
      chk("alt_window", data_out, data_in);
    end
    b = 1'($urandom(32'd12345));
    for (int w = 0; w < 200; w++) begin
      setd(1'($urandom));
      repeat (100) cyc();
      chk("rand_window", data_out, data_in);
    end
    for (int w = 0; w < 100; w++) begin
      setd(1'($urandom));
      for (int i = 0; i < 20; i++) begin
        cyc();
        if (stable >= 23) chk("rand20_track", data_out, data_in);
      end
    end
    setd(1);
    repeat (40) cyc();
    chk("pre_reset_dout", data_out, 1);
    #3 reset = 0;
    #1;
    chk("async_reset_dout", data_out, 0);
    chk("async_reset_sample", 32'(dut.sample), 0);
    chk("async_reset_run", dut.run, 0);
    cyc();
    reset = 1;
    for (int i = 0; i < 200; i++) begin
      if (i % 20 == 0) setd(!data_in);
      cyc();
      if (i % 20 == 19) chk("post_reset_idle", data_out, 0);
    end
    setd(1);
    start = 1;
    cyc();
    start = 0;
    wait_rise();
    chk("restart_latency", 32'(lat <= 23), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
